// File: rtl/fetch_stage.sv
// fetch_stage: PC, ready/ack imem port, one-entry fetch buffer, IF/ID reg.
// A redirect during an unacked fetch drains that request in DROP.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable_pc,
  input  logic        i_enable_if,
  input  logic        i_reset_if,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr_id,
  output logic [31:0] o_pc_id,
  output logic        o_valid_id,
  output logic        o_fetch_stall
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] stale_q;
  logic [31:0] buf_q;
  logic [31:0] buf_pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_id_q;
  logic        valid_q;

  logic [31:0] target;
  logic        accept;
  logic        flush;
  logic        unused_alu_lsb;

  assign target = {i_alu_data[31:2], 2'b00};
  assign unused_alu_lsb = ^i_alu_data[1:0];
  assign accept = (state_q == HOLD)
                & i_enable_if & i_enable_pc;
  assign flush = ~i_reset_if | i_pc_sel;

  assign o_imem_req = ~i_reset
                    & (state_q != HOLD);
  assign o_imem_addr = (state_q == DROP)
                     ? stale_q : pc_q;
  assign o_fetch_stall = i_enable_if & i_reset_if
                       & ~i_pc_sel
                       & (state_q != HOLD);

  assign o_instr_id = instr_q;
  assign o_pc_id    = pc_id_q;
  assign o_valid_id = valid_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      stale_q  <= '0;
      buf_q    <= '0;
      buf_pc_q <= '0;
      instr_q  <= NOP_INSTR;
      pc_id_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (flush) begin
        instr_q <= NOP_INSTR;
        pc_id_q <= '0;
        valid_q <= 1'b0;
      end else if (i_enable_if) begin
        if (accept) begin
          instr_q <= buf_q;
          pc_id_q <= buf_pc_q;
          valid_q <= 1'b1;
        end else begin
          instr_q <= NOP_INSTR;
          pc_id_q <= '0;
          valid_q <= 1'b0;
        end
      end

      if (i_pc_sel) begin
        pc_q <= target;
        unique case (state_q)
          FETCH: begin
            // keep the old address on the bus until memory acks it
            if (!i_imem_ack) begin
              state_q <= DROP;
              stale_q <= pc_q;
            end
          end
          HOLD:    state_q <= FETCH;
          default: state_q <= DROP;
        endcase
      end else begin
        unique case (state_q)
          FETCH: begin
            if (i_imem_ack) begin
              buf_q    <= i_imem_rdata;
              buf_pc_q <= pc_q;
              state_q  <= HOLD;
            end
          end
          HOLD: begin
            if (accept) begin
              pc_q    <= pc_q + 32'd4;
              state_q <= FETCH;
            end
          end
          default: begin
            if (i_imem_ack) state_q <= FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run
// against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, en_pc, en_if, rif, sel, ack;
  logic [31:0] alu, rdata;
  logic        req, valid, stall;
  logic [31:0] addr, instr, pcid;

  int vec = 0;
  int bad = 0;

  // model: fetching / holding a buffered instr / draining a stale request
  logic        m_hold, m_drop;
  logic [31:0] m_pc, m_stale, m_buf, m_bpc;
  logic [31:0] m_instr, m_pcid;
  logic        m_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_enable_pc(en_pc), .i_enable_if(en_if),
    .i_reset_if(rif), .i_pc_sel(sel),
    .i_alu_data(alu),
    .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata),
    .o_instr_id(instr), .o_pc_id(pcid),
    .o_valid_id(valid), .o_fetch_stall(stall)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic e_req();
    return !rst && !m_hold;
  endfunction

  function automatic logic [31:0] e_addr();
    return m_drop ? m_stale : m_pc;
  endfunction

  task automatic drive(input logic r, input logic epc, input logic eif,
                       input logic rf, input logic s, input logic [31:0] al,
                       input logic a, input logic [31:0] d);
    rst = r; en_pc = epc; en_if = eif; rif = rf;
    sel = s; alu = al; ack = a; rdata = d;
    #1;
  endtask

  task automatic tick();
    logic acc;
    if (rst) begin
      m_pc = RPC; m_hold = 0; m_drop = 0;
      m_instr = NOP; m_pcid = 0; m_valid = 0;
    end else begin
      acc = m_hold && en_if && en_pc;
      if (!rif || sel) begin
        m_instr = NOP; m_pcid = 0; m_valid = 0;
      end else if (en_if) begin
        if (acc) begin
          m_instr = m_buf; m_pcid = m_bpc; m_valid = 1;
        end else begin
          m_instr = NOP; m_pcid = 0; m_valid = 0;
        end
      end
      if (sel) begin
        if (!m_hold && !m_drop && !ack) begin
          m_drop = 1; m_stale = m_pc;
        end
        m_hold = 0;
        m_pc = {alu[31:2], 2'b00};
      end else if (m_drop) begin
        if (ack) m_drop = 0;
      end else if (m_hold) begin
        if (acc) begin m_pc = m_pc + 4; m_hold = 0; end
      end else if (ack) begin
        m_buf = rdata; m_bpc = m_pc; m_hold = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 1, 1, 1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req act=%b exp=0", req); end
    tick();
    drive(1, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req2 act=%b exp=0", req); end
    vec++; if (instr !== NOP) begin bad++; $display("FAIL rst_instr act=%h exp=%h", instr, NOP); end
    vec++; if (pcid !== 32'h0) begin bad++; $display("FAIL rst_pcid act=%h exp=0", pcid); end
    vec++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid act=%b exp=0", valid); end
    tick();
  endtask

  task automatic test_zero_wait();
    do_reset();
    drive(0, 1, 1, 1, 0, 0, 1, 32'h0050_0093);
    vec++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL zw_req act=%b/%h exp=1/0", req, addr); end
    tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (req !== 1'b0) begin bad++; $display("FAIL zw_hold_req act=%b exp=0", req); end
    tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL zw_instr act=%h exp=00500093", instr); end
    vec++; if (pcid !== 32'h0 || valid !== 1'b1) begin bad++; $display("FAIL zw_pcv act=%h/%b exp=0/1", pcid, valid); end
    vec++; if (addr !== 32'h4 || req !== 1'b1) begin bad++; $display("FAIL zw_next act=%h/%b exp=4/1", addr, req); end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 1, 0, 0, 0, 0);
      vec++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL dly_req[%0d] act=%b/%h exp=1/0", k, req, addr); end
      vec++; if (stall !== 1'b1) begin bad++; $display("FAIL dly_stall[%0d] act=%b exp=1", k, stall); end
      tick();
      vec++; if (instr !== NOP || valid !== 1'b0) begin bad++; $display("FAIL dly_bub[%0d] act=%h/%b exp=%h/0", k, instr, valid, NOP); end
    end
    drive(0, 1, 1, 1, 0, 0, 1, mem(0));
    tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (stall !== 1'b0) begin bad++; $display("FAIL dly_hstall act=%b exp=0", stall); end
    tick();
    vec++; if (instr !== mem(0) || valid !== 1'b1) begin bad++; $display("FAIL dly_instr act=%h/%b exp=%h/1", instr, valid, mem(0)); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    drive(0, 1, 1, 1, 0, 0, 1, mem(0)); tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);      tick();
    drive(0, 1, 1, 1, 0, 0, 1, mem(4)); tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 1, 0, 0, 0, 0);
      vec++; if (req !== 1'b0) begin bad++; $display("FAIL sh_req[%0d] act=%b exp=0", k, req); end
      tick();
      vec++; if (instr !== NOP || valid !== 1'b0) begin bad++; $display("FAIL sh_bub[%0d] act=%h/%b exp=%h/0", k, instr, valid, NOP); end
    end
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (instr !== mem(4) || pcid !== 32'h4 || valid !== 1'b1) begin bad++; $display("FAIL sh_rel act=%h/%h/%b exp=%h/4/1", instr, pcid, valid, mem(4)); end
    vec++; if (addr !== 32'h8) begin bad++; $display("FAIL sh_addr act=%h exp=8", addr); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    drive(0, 1, 1, 1, 1, 32'h103, 0, 0);
    tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL dr_stale act=%b/%h exp=1/0", req, addr); end
    tick();
    drive(0, 1, 1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (addr !== 32'h100 || req !== 1'b1) begin bad++; $display("FAIL dr_addr act=%h/%b exp=100/1", addr, req); end
    vec++; if (valid !== 1'b0) begin bad++; $display("FAIL dr_valid act=%b exp=0", valid); end
    drive(0, 1, 1, 1, 0, 0, 1, mem(32'h100)); tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);            tick();
    vec++; if (instr !== mem(32'h100) || pcid !== 32'h100) begin bad++; $display("FAIL dr_instr act=%h/%h exp=%h/100", instr, pcid, mem(32'h100)); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    drive(0, 1, 1, 1, 1, 32'h202, 1, mem(0));
    tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (instr !== NOP || valid !== 1'b0 || pcid !== 32'h0) begin bad++; $display("FAIL ra_ifid act=%h/%b/%h exp=%h/0/0", instr, valid, pcid, NOP); end
    vec++; if (req !== 1'b1 || addr !== 32'h200) begin bad++; $display("FAIL ra_addr act=%b/%h exp=1/200", req, addr); end
    tick();
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    drive(0, 1, 1, 1, 1, 32'h40, 0, 0);
    tick();
    drive(1, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (req !== 1'b0) begin bad++; $display("FAIL rd_req act=%b exp=0", req); end
    tick();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    vec++; if (req !== 1'b1 || addr !== RPC) begin bad++; $display("FAIL rd_addr act=%b/%h exp=1/%h", req, addr, RPC); end
    tick();
    vec++; if (valid !== 1'b0) begin bad++; $display("FAIL rd_v0 act=%b exp=0", valid); end
    drive(0, 1, 1, 1, 0, 0, 1, mem(RPC)); tick();
    vec++; if (valid !== 1'b0) begin bad++; $display("FAIL rd_v1 act=%b exp=0", valid); end
    drive(0, 1, 1, 1, 0, 0, 0, 0); tick();
    vec++; if (valid !== 1'b1 || pcid !== RPC) begin bad++; $display("FAIL rd_v2 act=%b/%h exp=1/%h", valid, pcid, RPC); end
  endtask

  task automatic test_random();
    logic r, a;
    logic e_stall;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 59) == 0);
      a = !r && !m_hold && ($urandom_range(0, 2) == 0);
      drive(r, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9,
            $urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
            $urandom, a, mem(e_addr()));
      e_stall = en_if && rif && !sel && !m_hold;
      vec++; if (req !== e_req()) begin bad++; $display("FAIL rnd_req[%0d] act=%b exp=%b", n, req, e_req()); end
      if (e_req()) begin
        vec++; if (addr !== e_addr()) begin bad++; $display("FAIL rnd_addr[%0d] act=%h exp=%h", n, addr, e_addr()); end
      end
      vec++; if (stall !== e_stall) begin bad++; $display("FAIL rnd_stall[%0d] act=%b exp=%b", n, stall, e_stall); end
      vec++; if (instr !== m_instr || pcid !== m_pcid || valid !== m_valid) begin
        bad++;
        $display("FAIL rnd_ifid[%0d] act=%h/%h/%b exp=%h/%h/%b", n, instr, pcid, valid, m_instr, m_pcid, m_valid);
      end
      tick();
    end
  endtask

  initial begin
    drive(1, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_stall_hold();
    test_redirect_drop();
    test_redirect_ack();
    test_reset_in_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
